stream_parity: RTL
==================

Name: stream_parity

Overview:
- Streaming per-group parity generator/checker; generalises the single-vector XOR-reduce parity to a WIDTH-bit data path split into NGROUP = WIDTH/GROUP lanes.
- Runtime-selectable even/odd sense and generate/check mode.
- Registered valid/ready output stage plus sticky error flag and saturating error counter.
- Sits on protected data paths (memory read return, bus bridges) between producer and consumer.

Parameters:
- WIDTH, 32, data word width in bits.
- GROUP, 8, bits per parity group; WIDTH % GROUP == 0 is required; elaboration error otherwise.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on accept.
- check_en  in  1  0 = generate, 1 = check; sampled on accept.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept.
- in_data  in  WIDTH  input word.
- in_par  in  NGROUP  received parity bits (check mode only); bit g covers in_data[g*GROUP +: GROUP].
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  registered copy of in_data.
- out_par  out  NGROUP  generated parity (generate) or in_par passthrough (check).
- out_err  out  NGROUP  per-group error flags; 0 in generate mode.
- err_clear  in  1  clears err_sticky and err_count.
- err_sticky  out  1  set on any accepted erroring word.
- err_count  out  CNT_W  count of accepted erroring words, saturating.

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid, out_data, out_par, out_err, err_sticky and err_count all 0. in_ready is combinational, so it reads 1 after reset. Reset mid-transfer drops the held word and does not count it.
- Per group g: p[g] = ^in_data[g] ^ odd_mode.
- Generate mode: out_par[g] = p[g]; out_err = 0.
- Check mode: out_par = in_par; out_err[g] = p[g] ^ in_par[g].
- Accept = in_valid & in_ready. On accept, every out_* field is loaded at the next edge with latency 1.
- in_ready = !out_valid | out_ready. Full throughput of one word per cycle while out_ready=1.
- out_valid: set on accept. Cleared when out_ready=1 and there is no accept in the same cycle. Stays 1 across back-to-back transfers.
- While out_valid=1 and out_ready=0: outputs are held stable and in_ready=0.
- No combinational path from in_data to out_*.
- Word error = |out_err value computed at accept, and only in check mode.
- err_count increments on an accepted erroring word. It saturates at 2^CNT_W-1 and does not wrap.
- err_sticky sets on an accepted erroring word.
- Both err_count and err_sticky update at the same edge as out_err, independent of out_ready.
- err_clear alone: err_count=0 and err_sticky=0 at next edge.
- err_clear together with an erroring accept: the new event wins, giving err_count=1 and err_sticky=1.
- odd_mode/check_en changes affect only words accepted after the change. The held word is unaffected.

Decomposition:
- Package stream_parity_pkg:
  - localparam function ngroup(WIDTH, GROUP).
  - function group_parity(data, odd) returning the NGROUP vector.
  - typedef for the counter saturation constant.
- Per-group reduction instantiates the library Parity primitive NGROUP times.
- One sub-module: parity_err_counter. It holds the saturating counter and sticky flag, with inputs inc and clear, and implements the clear/increment priority rule.

Test Plan:
- Generate, even, WIDTH=32/GROUP=8: in_data=0x01030700 -> one cycle later out_par=4'b1010, out_err=0, err_count=0. Repeat with odd_mode=1 -> out_par=4'b0101.
- Check, odd: in_data=0x00000000 with in_par=4'b1111 -> out_err=0. Next word in_par=4'b1110 -> out_err=4'b0001, err_sticky=1, err_count=1.
- Backpressure: out_ready=0 for 3 cycles while 2 words are offered -> first word held stable, in_ready=0, no loss. Release gives words out in order, and no bubble with continuous valid.
- Saturation, CNT_W=4: 20 consecutive erroring words -> err_count stops at 15, err_sticky=1.
- Clear priority: err_clear with an erroring accept -> err_count=1, err_sticky=1. err_clear alone next cycle -> 0, 0.
- Reset mid-stream: rst_n=0 while out_valid=1 and err_count=5 -> after edge out_valid=0, err_count=0, err_sticky=0, in_ready=1.

Source files
------------

// File: rtl/stream_parity_pkg.sv
// Shared constants and helpers for the stream_parity block.
package stream_parity_pkg;

    localparam int MAX_W = 1024;

    typedef int unsigned sat_t;

    function automatic int ngroup(input int width, input int group);
        return width / group;
    endfunction

    // Largest value a cnt_w-bit saturating counter may hold.
    function automatic sat_t sat_max(input int cnt_w);
        return (cnt_w >= 32) ? 32'hffff_ffff : ((32'd1 << cnt_w) - 32'd1);
    endfunction

    // Reference per-group parity; bits above ngrp in the result are zero.
    function automatic logic [MAX_W-1:0] group_parity(input logic [MAX_W-1:0] data,
                                                      input int group, input int ngrp,
                                                      input logic odd);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int g = 0; g < ngrp; g++) begin
            r[g] = odd;
            for (int b = 0; b < group; b++) r[g] = r[g] ^ data[g*group + b];
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_parity_err_counter.sv
// Saturating error counter with sticky flag; a new error beats a same-cycle clear.
module parity_err_counter
    import stream_parity_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic             sticky,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            sticky <= 1'b0;
        end else if (inc) begin
            sticky <= 1'b1;
            if (clear)           count <= CNT_W'(1);
            else if (count != SAT) count <= count + CNT_W'(1);
        end else if (clear) begin
            count  <= '0;
            sticky <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_parity_parity.sv
// Library parity primitive: XOR-reduce of one W-bit vector.
module parity #(
    parameter int W = 8
) (
    input  logic [W-1:0] d,
    output logic         p
);
    assign p = ^d;
endmodule

// File: rtl/stream_parity.sv
// Streaming per-group parity generator/checker with a one-deep registered output stage.
module stream_parity
    import stream_parity_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    parameter int CNT_W = 16,
    localparam int NGROUP = ngroup(WIDTH, GROUP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              check_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [NGROUP-1:0] in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [NGROUP-1:0] out_par,
    output logic [NGROUP-1:0] out_err,
    input  logic              err_clear,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);
    if (WIDTH % GROUP != 0) begin : g_bad_cfg
        $error("stream_parity: WIDTH must be a multiple of GROUP");
    end

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [NGROUP-1:0] par;
        logic [NGROUP-1:0] err;
    } rsp_t;

    logic [NGROUP-1:0] lane_p;
    logic [NGROUP-1:0] p;
    logic              accept;
    logic              word_err;
    rsp_t              nxt, rsp;

    for (genvar g = 0; g < NGROUP; g++) begin : g_lane
        parity #(.W(GROUP)) u_par (.d(in_data[g*GROUP +: GROUP]), .p(lane_p[g]));
    end

    assign p        = lane_p ^ {NGROUP{odd_mode}};
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        nxt.data = in_data;
        nxt.par  = check_en ? in_par : p;
        nxt.err  = check_en ? (p ^ in_par) : '0;
    end

    assign word_err = accept && check_en && (|nxt.err);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rsp       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rsp       <= nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_data = rsp.data;
    assign out_par  = rsp.par;
    assign out_err  = rsp.err;

    parity_err_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (word_err),
        .clear  (err_clear),
        .sticky (err_sticky),
        .count  (err_count)
    );
endmodule
